// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and defaults for the sequence transmitter
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } seq_state_t;

  localparam int SEQ_DATA_WIDTH = 32;
  localparam int SEQ_DEPTH      = 8;

  // Width able to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/seq_buf.sv
// rtl/seq_buf.sv - element storage with one write port and a combinational read port
module seq_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[widx] <= wdata;
  end

  assign rdata = r_mem[ridx];

endmodule

// File: rtl/seq_stream_tx.sv
// rtl/seq_stream_tx.sv - buffers up to DEPTH words and replays them once as a framed stream
module seq_stream_tx
  import seq_pkg::*;
#(
  parameter int DATA_WIDTH = SEQ_DATA_WIDTH,
  parameter int DEPTH      = SEQ_DEPTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_ready,
  output logic [cnt_width(DEPTH)-1:0]   count,
  input  logic                          start,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_first,
  output logic                          out_last,
  output logic                          done
);

  localparam int CW = cnt_width(DEPTH);
  localparam int IW = $clog2(DEPTH);

  seq_state_t      r_state;
  logic [CW-1:0]   r_count;
  logic [IW-1:0]   r_rd_idx;

  logic                  w_wr_ready;
  logic                  w_wr_accept;
  logic                  w_start;
  logic                  w_xfer;
  logic                  w_is_last;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_wr_ready  = (r_state == IDLE) && (r_count < CW'(DEPTH));
  assign w_wr_accept = wr_en && w_wr_ready;
  // Uses the pre-write count, so a write into an empty buffer cannot start a sequence.
  assign w_start     = (r_state == IDLE) && start && (r_count != '0);
  assign w_xfer      = (r_state == STREAM) && out_ready;
  assign w_is_last   = (CW'(r_rd_idx) == (r_count - CW'(1)));

  seq_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (w_wr_accept),
    .widx  (r_count[IW-1:0]),
    .wdata (wr_data),
    .ridx  (r_rd_idx),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_rd_idx <= '0;
    end else begin
      if (w_wr_accept) r_count <= r_count + CW'(1);
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state  <= STREAM;
            r_rd_idx <= '0;
          end
        end
        STREAM: begin
          if (w_xfer) begin
            r_rd_idx <= r_rd_idx + IW'(1);
            if (w_is_last) r_state <= DONE;
          end
        end
        DONE: begin
          r_state  <= IDLE;
          r_count  <= '0;
          r_rd_idx <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_ready  = w_wr_ready;
  assign count     = r_count;
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == STREAM);
  assign out_data  = out_valid ? w_rdata : '0;
  assign out_first = out_valid && (r_rd_idx == '0);
  assign out_last  = out_valid && w_is_last;
  assign done      = (r_state == DONE);

endmodule
